fetch_stage: RTL and testbench

Instruction fetch stage of the 16-bit five-stage pipeline. Holds the program counter and drives the instruction-memory address. Selects the next PC from sequential increment, an 8-entry bimodal branch predictor, or an execute-stage redirect. Its outputs feed the IF/ID pipeline register directly, and it tracks a RUN/HALTED state so a fetched HALT freezes the front end until it retires or is flushed.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect/train inputs and IF/ID outputs.
// master = fetch stage side, slave = surrounding pipeline / memory side.
interface fetch_if;
  logic [15:0] imem_addr;
  logic [15:0] instruction_in;
  logic        STALL_IN;
  logic        redirect_in;
  logic [15:0] redirect_pc_in;
  logic        bp_update_in;
  logic [15:0] bp_update_pc_in;
  logic        bp_update_taken_in;
  logic [15:0] PC_NO_PLUS_TWO_OUT;
  logic [15:0] PC_next_out;
  logic [15:0] instruction_out;
  logic        predict_taken_out;
  logic        HALT_OUT;

  modport master (
    output imem_addr, PC_NO_PLUS_TWO_OUT, PC_next_out, instruction_out,
           predict_taken_out, HALT_OUT,
    input  instruction_in, STALL_IN, redirect_in, redirect_pc_in,
           bp_update_in, bp_update_pc_in, bp_update_taken_in
  );

  modport slave (
    input  imem_addr, PC_NO_PLUS_TWO_OUT, PC_next_out, instruction_out,
           predict_taken_out, HALT_OUT,
    output instruction_in, STALL_IN, redirect_in, redirect_pc_in,
           bp_update_in, bp_update_pc_in, bp_update_taken_in
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED front-end freeze and optional
// 8-entry bimodal predictor enabled by the BRANCH_PREDICT_EN macro.
module fetch_stage (
  input logic   clk,
  input logic   rst,
  fetch_if.master bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next, pc_plus_two, branch_target;
  logic [4:0]  opcode;
  logic        is_branch, is_halt, predict_raw, predict_taken;

  assign pc_plus_two   = pc + 16'd2;
  assign opcode        = bus.instruction_in[15:11];
  assign is_branch     = (opcode[4:2] == 3'b011);
  assign is_halt       = (opcode == 5'b00000);
  assign branch_target = pc_plus_two + {{8{bus.instruction_in[7]}}, bus.instruction_in[7:0]};

`ifdef BRANCH_PREDICT_EN
  logic [1:0] counters [8];
  logic [2:0] update_idx;

  assign update_idx  = bus.bp_update_pc_in[3:1];
  // Lookup reads the pre-edge counter, so a same-cycle update is not yet visible.
  assign predict_raw = is_branch & counters[pc[3:1]][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) counters[i] <= 2'b01;
    end else if (bus.bp_update_in) begin
      if (bus.bp_update_taken_in) begin
        if (counters[update_idx] != 2'b11) counters[update_idx] <= counters[update_idx] + 2'd1;
      end else begin
        if (counters[update_idx] != 2'b00) counters[update_idx] <= counters[update_idx] - 2'd1;
      end
    end
  end
`else
  logic unused_bp;
  assign unused_bp   = ^{bus.bp_update_in, bus.bp_update_pc_in, bus.bp_update_taken_in, is_branch};
  assign predict_raw = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!bus.redirect_in && !bus.STALL_IN && is_halt) state_next = HALTED;
      HALTED:  if (bus.redirect_in) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // A frozen front end presents NOPs so the HALT is issued exactly once.
  always_comb begin
    bus.instruction_out   = bus.instruction_in;
    bus.HALT_OUT          = is_halt;
    predict_taken         = predict_raw;
    if (state == HALTED) begin
      bus.instruction_out = 16'h0800;
      bus.HALT_OUT        = 1'b0;
      predict_taken       = 1'b0;
    end
  end

  assign bus.predict_taken_out  = predict_taken;
  assign bus.imem_addr          = pc;
  assign bus.PC_NO_PLUS_TWO_OUT = pc;
  assign bus.PC_next_out        = pc_plus_two;

  always_comb begin
    if (bus.redirect_in)                      pc_next = bus.redirect_pc_in;
    else if (bus.STALL_IN || state == HALTED) pc_next = pc;
    else if (predict_taken)                   pc_next = branch_target;
    else                                      pc_next = pc_plus_two;
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= 16'h0000;
    else     pc <= pc_next;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

  localparam logic [15:0] NOP  = 16'h0800;
  localparam logic [15:0] HALT = 16'h0000;
  localparam logic [15:0] BEQZ = 16'h60F0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [15:0] m_pc;
  bit          m_halted;
  int          m_ctr [8];
  bit          m_valid = 0;

  task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit modelPredict(input logic [15:0] instr, input logic [15:0] pc);
    int op;
    op = int'(instr[15:11]);
`ifdef BRANCH_PREDICT_EN
    return (op >= 12 && op <= 15) && (m_ctr[(int'(pc) / 2) % 8] >= 2);
`else
    return 1'b0 && (op >= 0) && (pc == pc);
`endif
  endfunction

  task automatic checkOutput(input logic [15:0] instr);
    logic [15:0] exp_instr;
    bit exp_halt, exp_pred;
    exp_instr = m_halted ? NOP : instr;
    exp_halt  = !m_halted && (instr[15:11] == 5'd0);
    exp_pred  = !m_halted && modelPredict(instr, m_pc);
    checkOne("imem_addr", bus.imem_addr, m_pc);
    checkOne("pc_no_plus_two", bus.PC_NO_PLUS_TWO_OUT, m_pc);
    checkOne("pc_next", bus.PC_next_out, 16'((int'(m_pc) + 2) % 65536));
    checkOne("instruction_out", bus.instruction_out, exp_instr);
    checkOne("halt_out", {15'd0, bus.HALT_OUT}, {15'd0, exp_halt});
    checkOne("predict_taken", {15'd0, bus.predict_taken_out}, {15'd0, exp_pred});
  endtask

  task automatic modelStep(input logic [15:0] instr, input bit stall, input bit redir,
                           input logic [15:0] rpc, input bit upd, input logic [15:0] upc,
                           input bit utk, input bit r);
    bit pred, hlt;
    int disp;
    pred = !m_halted && modelPredict(instr, m_pc);
    hlt  = !m_halted && (instr[15:11] == 5'd0);
    if (r) begin
      m_pc = 16'h0000;
      m_halted = 0;
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_valid = 1;
      return;
    end
`ifdef BRANCH_PREDICT_EN
    if (upd) begin
      int idx;
      idx = (int'(upc) / 2) % 8;
      if (utk) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
      else     m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
    end
`endif
    disp = int'(instr[7:0]);
    if (disp > 127) disp -= 256;
    if (redir)                    m_pc = rpc;
    else if (stall || m_halted)   m_pc = m_pc;
    else if (pred)                m_pc = 16'((int'(m_pc) + 2 + disp + 65536) % 65536);
    else                          m_pc = 16'((int'(m_pc) + 2) % 65536);
    if (redir)                          m_halted = 0;
    else if (!m_halted && !stall && hlt) m_halted = 1;
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input bit stall, input bit redir,
                               input logic [15:0] rpc, input bit upd, input logic [15:0] upc,
                               input bit utk, input bit r);
    @(negedge clk);
    rst                    = r;
    bus.instruction_in     = instr;
    bus.STALL_IN           = stall;
    bus.redirect_in        = redir;
    bus.redirect_pc_in     = rpc;
    bus.bp_update_in       = upd;
    bus.bp_update_pc_in    = upc;
    bus.bp_update_taken_in = utk;
    #1;
    if (m_valid) checkOutput(instr);
    modelStep(instr, stall, redir, rpc, upd, upc, utk, r);
  endtask

  task automatic step(input logic [15:0] instr, input bit stall = 0, input bit redir = 0,
                      input logic [15:0] rpc = 16'h0000);
    applyStimulus(instr, stall, redir, rpc, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [15:0] upc, input bit tk);
    applyStimulus(NOP, 1'b0, 1'b0, 16'h0000, 1'b1, upc, tk, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(NOP, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] rnd, rnd2;
    logic [15:0] instr, rpc, upc;
    bit stall, redir, upd, utk, r;

    doReset();
    step(NOP); checkOne("lit_seq0", bus.imem_addr, 16'h0000);
    step(NOP); checkOne("lit_seq2", bus.imem_addr, 16'h0002);
    checkOne("lit_seq2_next", bus.PC_next_out, 16'h0004);
    step(NOP); checkOne("lit_seq4", bus.imem_addr, 16'h0004);
    step(NOP); checkOne("lit_seq6", bus.imem_addr, 16'h0006);

    // Branch at 0x0010 with untrained then trained counter
    step(NOP, 0, 1, 16'h0010);
    step(BEQZ); checkOne("lit_beqz_untrained", {15'd0, bus.predict_taken_out}, 16'd0);
    step(NOP);  checkOne("lit_beqz_fallthru", bus.imem_addr, 16'h0012);
    train(16'h0010, 1); train(16'h0010, 1);
    step(NOP, 0, 1, 16'h0010);
    step(BEQZ);
`ifdef BRANCH_PREDICT_EN
    checkOne("lit_beqz_trained", {15'd0, bus.predict_taken_out}, 16'd1);
    step(NOP); checkOne("lit_beqz_target", bus.imem_addr, 16'h0002);
`else
    checkOne("lit_beqz_trained", {15'd0, bus.predict_taken_out}, 16'd0);
    step(NOP); checkOne("lit_beqz_target", bus.imem_addr, 16'h0012);
`endif

    // Stall hold, then redirect wins over stall
    step(NOP, 0, 1, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      step(NOP, 1);
      checkOne("lit_stall_addr", bus.imem_addr, 16'h0020);
      checkOne("lit_stall_instr", bus.instruction_out, NOP);
    end
    step(NOP, 1, 1, 16'h0100);
    step(NOP); checkOne("lit_stall_redirect", bus.imem_addr, 16'h0100);

    // HALT issued once, front end frozen until redirect
    step(NOP, 0, 1, 16'h0030);
    step(HALT); checkOne("lit_halt_out", {15'd0, bus.HALT_OUT}, 16'd1);
    step(HALT); checkOne("lit_halted_addr", bus.imem_addr, 16'h0032);
    checkOne("lit_halted_nop", bus.instruction_out, 16'h0800);
    checkOne("lit_halted_halt", {15'd0, bus.HALT_OUT}, 16'd0);
    step(HALT); checkOne("lit_halted_frozen", bus.imem_addr, 16'h0032);
    step(HALT, 0, 1, 16'h0040);
    step(16'h1234); checkOne("lit_resume_addr", bus.imem_addr, 16'h0040);
    checkOne("lit_resume_instr", bus.instruction_out, 16'h1234);

    // Counter saturation at index 3
    for (int i = 0; i < 5; i++) train(16'h0016, 1);
    train(16'h0016, 0);
    step(NOP, 0, 1, 16'h0016);
    step(BEQZ);
`ifdef BRANCH_PREDICT_EN
    checkOne("lit_sat_10", {15'd0, bus.predict_taken_out}, 16'd1);
`else
    checkOne("lit_sat_10", {15'd0, bus.predict_taken_out}, 16'd0);
`endif
    for (int i = 0; i < 3; i++) train(16'h0016, 0);
    train(16'h0016, 1);
    step(NOP, 0, 1, 16'h0016);
    step(BEQZ); checkOne("lit_sat_00", {15'd0, bus.predict_taken_out}, 16'd0);

    // PC wrap
    step(NOP, 0, 1, 16'hFFFE);
    step(NOP); checkOne("lit_wrap_next", bus.PC_next_out, 16'h0000);
    step(NOP); checkOne("lit_wrap_addr", bus.imem_addr, 16'h0000);

    // Reset while halted
    step(NOP, 0, 1, 16'h0030);
    step(HALT);
    step(HALT); checkOne("lit_pre_rst_halted", bus.instruction_out, 16'h0800);
    doReset();
    step(NOP); checkOne("lit_rst_addr", bus.imem_addr, 16'h0000);
    step(NOP, 0, 1, 16'h0010);
    step(BEQZ); checkOne("lit_rst_counter", {15'd0, bus.predict_taken_out}, 16'd0);
    step(HALT); checkOne("lit_rst_run", {15'd0, bus.HALT_OUT}, 16'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rnd  = $urandom();
      rnd2 = $urandom();
      case (rnd[3:0])
        4'd0:                      instr = {5'b00000, rnd2[10:0]};
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: instr = {3'b011, rnd2[12:0]};
        default:                   instr = rnd2[31:16];
      endcase
      stall = (rnd[7:4] < 4'd3);
      redir = (rnd[11:8] < 4'd3);
      rpc   = {rnd2[31:17], 1'b0};
      upd   = (rnd[15:12] < 4'd6);
      upc   = {11'd0, rnd[20:16], 1'b0};
      utk   = rnd[21];
      r     = (rnd[27:22] == 6'd0);
      applyStimulus(instr, stall, redir, rpc, upd, upc, utk, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
